// File: rtl/axilite_naive_master.sv
// AXI4-Lite master: turns a single-request port into one AXI-Lite read or
// write transaction at a time. No bursts, no reordering, no response
// backpressure.
module axilite_naive_master #(
  parameter bit ALIGN_ADDR = 1'b1
) (
  input  logic        axi_clk,
  input  logic        axi_resetn,
  // request / response port
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  // AXI-Lite write address
  output logic [31:0] axi_awaddr,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  // AXI-Lite write data
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  // AXI-Lite write response
  input  logic [1:0]  axi_bresp,
  input  logic        axi_bvalid,
  output logic        axi_bready,
  // AXI-Lite read address
  output logic [31:0] axi_araddr,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  // AXI-Lite read data
  input  logic [31:0] axi_rdata,
  input  logic [1:0]  axi_rresp,
  input  logic        axi_rvalid,
  output logic        axi_rready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4
  } state_t;

  state_t      state;
  logic [31:0] addr_al;
  logic        aw_done;
  logic        w_done;

  // Word-align the outgoing address when requested; low bits dropped.
  assign addr_al   = ALIGN_ADDR ? {req_addr[31:2], 2'b00} : req_addr;

  // Only one transaction in flight, so ready is simply "idle".
  assign req_ready = (state == IDLE);

  // A write channel counts as done if its valid already dropped or it
  // handshakes on this edge; lets AW and W finish in either order.
  assign aw_done   = ~axi_awvalid | axi_awready;
  assign w_done    = ~axi_wvalid  | axi_wready;

  // Transaction FSM with all AXI and response outputs registered.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state       <= IDLE;
      axi_awaddr  <= '0;
      axi_awvalid <= 1'b0;
      axi_wdata   <= '0;
      axi_wstrb   <= '0;
      axi_wvalid  <= 1'b0;
      axi_bready  <= 1'b0;
      axi_araddr  <= '0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
    end else begin
      // completion pulse lasts exactly one cycle
      resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_wen) begin
              axi_awaddr  <= addr_al;
              axi_wdata   <= req_wdata;
              axi_wstrb   <= req_wstrb;
              axi_awvalid <= 1'b1;
              axi_wvalid  <= 1'b1;
              state       <= WADDR;
            end else begin
              axi_araddr  <= addr_al;
              axi_arvalid <= 1'b1;
              state       <= RADDR;
            end
          end
        end
        WADDR: begin
          if (axi_awvalid && axi_awready) axi_awvalid <= 1'b0;
          if (axi_wvalid && axi_wready)   axi_wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            axi_bready <= 1'b1;
            state      <= WRESP;
          end
        end
        WRESP: begin
          if (axi_bvalid && axi_bready) begin
            axi_bready <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= axi_bresp[1];
            state      <= IDLE;
          end
        end
        RADDR: begin
          if (axi_arvalid && axi_arready) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
            state       <= RDATA;
          end
        end
        RDATA: begin
          if (axi_rvalid && axi_rready) begin
            axi_rready <= 1'b0;
            resp_rdata <= axi_rdata;
            resp_err   <= axi_rresp[1];
            resp_valid <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axilite_naive_master.sv
// Bench for axilite_naive_master: a delay-programmable AXI-Lite slave,
// handshake monitor, and scenario tasks checked against a latency/data model.
module tb_axilite_naive_master;

  logic        axi_clk = 1'b0;
  logic        axi_resetn;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
  logic [3:0]  axi_wstrb;
  logic [1:0]  axi_bresp, axi_rresp;
  logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready;
  logic        axi_rvalid, axi_rready;

  int total = 0;
  int bad   = 0;

  // slave configuration
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  bit          junk_en = 0;
  logic [1:0]  sl_bresp = 2'b00, sl_rresp = 2'b00;
  logic [31:0] sl_rdata = 32'h0;
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;

  // monitor state
  int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
  int          aw_cyc = 0, w_cyc = 0, b_cyc = 0, ar_cyc = 0, r_cyc = 0;
  logic [31:0] cap_awaddr = 0, cap_wdata = 0, cap_araddr = 0;
  logic [3:0]  cap_wstrb = 0;
  int          stab_err = 0, inv_err = 0;
  logic        aw_hold = 0, w_hold = 0, ar_hold = 0, rv_prev = 0;
  logic [31:0] aw_prev = 0, w_prev = 0, ar_prev = 0;
  logic [3:0]  ws_prev = 0;

  logic [31:0] exp_rdata = 32'h0;

  axilite_naive_master #(.ALIGN_ADDR(1'b1)) dut (
    .axi_clk(axi_clk), .axi_resetn(axi_resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready), .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  always #5 axi_clk = ~axi_clk;

  // Slave: each channel answers after a programmed number of wait cycles;
  // B/R optionally toggle junk valids while the master is not ready.
  always @(negedge axi_clk) begin
    bit rdy;
    rdy = axi_awvalid && (aw_cnt >= aw_dly);
    axi_awready <= rdy;
    aw_cnt <= (!axi_awvalid || rdy) ? 0 : aw_cnt + 1;
    rdy = axi_wvalid && (w_cnt >= w_dly);
    axi_wready <= rdy;
    w_cnt <= (!axi_wvalid || rdy) ? 0 : w_cnt + 1;
    rdy = axi_arvalid && (ar_cnt >= ar_dly);
    axi_arready <= rdy;
    ar_cnt <= (!axi_arvalid || rdy) ? 0 : ar_cnt + 1;
    rdy = axi_bready && (b_cnt >= b_dly);
    axi_bvalid <= axi_bready ? rdy : (junk_en && $urandom_range(0, 1) == 1);
    axi_bresp  <= rdy ? sl_bresp : ~sl_bresp;
    b_cnt <= (!axi_bready || rdy) ? 0 : b_cnt + 1;
    rdy = axi_rready && (r_cnt >= r_dly);
    axi_rvalid <= axi_rready ? rdy : (junk_en && $urandom_range(0, 1) == 1);
    axi_rdata  <= rdy ? sl_rdata : ~sl_rdata;
    axi_rresp  <= rdy ? sl_rresp : ~sl_rresp;
    r_cnt <= (!axi_rready || rdy) ? 0 : r_cnt + 1;
  end

  // Monitor: handshake counts, valid-high cycle counts, captured payloads,
  // payload stability while stalled, and protocol invariants.
  always @(posedge axi_clk) begin
    if (axi_resetn) begin
      if (axi_awvalid) aw_cyc <= aw_cyc + 1;
      if (axi_wvalid)  w_cyc  <= w_cyc + 1;
      if (axi_bready)  b_cyc  <= b_cyc + 1;
      if (axi_arvalid) ar_cyc <= ar_cyc + 1;
      if (axi_rready)  r_cyc  <= r_cyc + 1;
      if (axi_awvalid && axi_awready) begin n_aw <= n_aw + 1; cap_awaddr <= axi_awaddr; end
      if (axi_wvalid && axi_wready) begin
        n_w <= n_w + 1; cap_wdata <= axi_wdata; cap_wstrb <= axi_wstrb;
      end
      if (axi_bvalid && axi_bready)   n_b <= n_b + 1;
      if (axi_arvalid && axi_arready) begin n_ar <= n_ar + 1; cap_araddr <= axi_araddr; end
      if (axi_rvalid && axi_rready)   n_r <= n_r + 1;
      if ((aw_hold && axi_awaddr !== aw_prev) || (ar_hold && axi_araddr !== ar_prev) ||
          (w_hold && (axi_wdata !== w_prev || axi_wstrb !== ws_prev)))
        stab_err <= stab_err + 1;
      if (axi_bready && (axi_awvalid || axi_wvalid)) inv_err <= inv_err + 1;
      if (resp_valid && rv_prev) inv_err <= inv_err + 1;
    end
    aw_hold <= axi_resetn && axi_awvalid && !axi_awready;
    w_hold  <= axi_resetn && axi_wvalid && !axi_wready;
    ar_hold <= axi_resetn && axi_arvalid && !axi_arready;
    aw_prev <= axi_awaddr; w_prev <= axi_wdata; ws_prev <= axi_wstrb;
    ar_prev <= axi_araddr;
    rv_prev <= axi_resetn && resp_valid;
  end

  // One full transaction through the request port, checked against the
  // model: latency from slave delays, payloads, handshake/valid counts.
  task automatic run_txn(input bit wen, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    int s_aw, s_w, s_b, s_ar, s_r, s_awc, s_wc, s_bc, s_arc, s_rc;
    int lat, exp_lat, mx;
    bit got;
    logic [31:0] ea;
    ea = {a[31:2], 2'b00};
    mx = (aw_dly > w_dly) ? aw_dly : w_dly;
    exp_lat = wen ? (3 + mx + b_dly) : (3 + ar_dly + r_dly);
    s_aw = n_aw; s_w = n_w; s_b = n_b; s_ar = n_ar; s_r = n_r;
    s_awc = aw_cyc; s_wc = w_cyc; s_bc = b_cyc; s_arc = ar_cyc; s_rc = r_cyc;
    @(negedge axi_clk);
    req_valid = 1'b1; req_wen = wen; req_addr = a; req_wdata = d; req_wstrb = s;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin got = 1; break; end
      @(negedge axi_clk);
    end
    total++;
    if (!got) begin bad++; $display("FAIL accept_timeout got=0 exp=1"); end
    @(negedge axi_clk);
    req_valid = 1'b0;
    got = 0; lat = 0;
    for (int i = 1; i <= 200; i++) begin
      if (resp_valid) begin got = 1; lat = i; break; end
      total++;
      if (req_ready !== 1'b0) begin bad++; $display("FAIL busy_req_ready got=%b exp=0", req_ready); end
      @(negedge axi_clk);
    end
    total++;
    if (!got) begin bad++; $display("FAIL resp_timeout got=0 exp=1"); end
    total++;
    if (lat != exp_lat) begin bad++; $display("FAIL latency got=%0d exp=%0d", lat, exp_lat); end
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL resp_cycle_ready got=%b exp=1", req_ready); end
    if (wen) begin
      total++;
      if (resp_err !== sl_bresp[1]) begin bad++; $display("FAIL wr_err got=%b exp=%b", resp_err, sl_bresp[1]); end
      total++;
      if (resp_rdata !== exp_rdata) begin bad++; $display("FAIL wr_rdata_hold got=%h exp=%h", resp_rdata, exp_rdata); end
      total++;
      if (cap_awaddr !== ea) begin bad++; $display("FAIL awaddr got=%h exp=%h", cap_awaddr, ea); end
      total++;
      if (cap_wdata !== d || cap_wstrb !== s) begin
        bad++; $display("FAIL wdata got=%h/%h exp=%h/%h", cap_wdata, cap_wstrb, d, s);
      end
      total++;
      if (n_aw - s_aw != 1 || n_w - s_w != 1 || n_b - s_b != 1 || n_ar != s_ar || n_r != s_r) begin
        bad++; $display("FAIL wr_handshakes got=%0d/%0d/%0d/%0d/%0d exp=1/1/1/0/0",
                        n_aw - s_aw, n_w - s_w, n_b - s_b, n_ar - s_ar, n_r - s_r);
      end
      total++;
      if (aw_cyc - s_awc != aw_dly + 1 || w_cyc - s_wc != w_dly + 1 || b_cyc - s_bc != b_dly + 1) begin
        bad++; $display("FAIL wr_valid_cycles got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                        aw_cyc - s_awc, w_cyc - s_wc, b_cyc - s_bc, aw_dly + 1, w_dly + 1, b_dly + 1);
      end
    end else begin
      exp_rdata = sl_rdata;
      total++;
      if (resp_err !== sl_rresp[1]) begin bad++; $display("FAIL rd_err got=%b exp=%b", resp_err, sl_rresp[1]); end
      total++;
      if (resp_rdata !== exp_rdata) begin bad++; $display("FAIL rd_data got=%h exp=%h", resp_rdata, exp_rdata); end
      total++;
      if (cap_araddr !== ea) begin bad++; $display("FAIL araddr got=%h exp=%h", cap_araddr, ea); end
      total++;
      if (n_ar - s_ar != 1 || n_r - s_r != 1 || n_aw != s_aw || n_w != s_w || n_b != s_b) begin
        bad++; $display("FAIL rd_handshakes got=%0d/%0d exp=1/1", n_ar - s_ar, n_r - s_r);
      end
      total++;
      if (ar_cyc - s_arc != ar_dly + 1 || r_cyc - s_rc != r_dly + 1) begin
        bad++; $display("FAIL rd_valid_cycles got=%0d/%0d exp=%0d/%0d",
                        ar_cyc - s_arc, r_cyc - s_rc, ar_dly + 1, r_dly + 1);
      end
    end
    @(negedge axi_clk);
    total++;
    if (resp_valid !== 1'b0) begin bad++; $display("FAIL resp_pulse_width got=%b exp=0", resp_valid); end
  endtask

  task automatic set_dly(input int aw, input int w, input int b, input int ar, input int r);
    aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
  endtask

  task automatic test_reset();
    axi_resetn = 1'b0; req_valid = 1'b0; req_wen = 1'b0;
    req_addr = '0; req_wdata = '0; req_wstrb = '0;
    #3;
    total++;
    if ({axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready, resp_valid, resp_err} !== 7'b0 ||
        resp_rdata !== 32'h0 || axi_awaddr !== 32'h0 || axi_araddr !== 32'h0 ||
        axi_wdata !== 32'h0 || axi_wstrb !== 4'h0) begin
      bad++; $display("FAIL reset_outputs got=%b rdata=%h exp=0",
                      {axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready, resp_valid, resp_err}, resp_rdata);
    end
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    repeat (2) @(negedge axi_clk);
    axi_resetn = 1'b1;
    exp_rdata = 32'h0;
  endtask

  task automatic test_write_basic();
    set_dly(0, 0, 0, 0, 0);
    sl_bresp = 2'b00;
    run_txn(1'b1, 32'h1000_0007, 32'hDEAD_BEEF, 4'hF);
  endtask

  task automatic test_write_skew();
    set_dly(3, 0, 1, 0, 0);
    sl_bresp = 2'b10;
    run_txn(1'b1, 32'h0000_0ABC, 32'h0BAD_F00D, 4'h5);
    total++;
    if (stab_err != 0 || inv_err != 0) begin
      bad++; $display("FAIL skew_stability got=%0d/%0d exp=0/0", stab_err, inv_err);
    end
  endtask

  task automatic test_read();
    set_dly(0, 0, 0, 0, 4);
    sl_rdata = 32'h1234_5678; sl_rresp = 2'b10;
    run_txn(1'b0, 32'h0000_0020, 32'h0, 4'h0);
  endtask

  task automatic test_back_to_back();
    bit got;
    set_dly(0, 0, 0, 0, 0);
    sl_bresp = 2'b00; sl_rdata = 32'hCAFE_0123; sl_rresp = 2'b00;
    @(negedge axi_clk);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h44; req_wdata = 32'h1111_2222; req_wstrb = 4'h3;
    @(negedge axi_clk);
    req_wen = 1'b0; req_addr = 32'h88;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      if (resp_valid) begin got = 1; break; end
      @(negedge axi_clk);
    end
    total++;
    if (!got || req_ready !== 1'b1 || resp_err !== 1'b0) begin
      bad++; $display("FAIL b2b_write_resp got=%b/%b exp=1/1", got, req_ready);
    end
    @(negedge axi_clk);
    total++;
    if (req_ready !== 1'b0 || axi_arvalid !== 1'b1 || axi_araddr !== 32'h88) begin
      bad++; $display("FAIL b2b_read_accept got=%b/%b/%h exp=0/1/88", req_ready, axi_arvalid, axi_araddr);
    end
    req_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      if (resp_valid) begin got = 1; break; end
      @(negedge axi_clk);
    end
    exp_rdata = sl_rdata;
    total++;
    if (!got || resp_rdata !== exp_rdata) begin
      bad++; $display("FAIL b2b_read_data got=%h exp=%h", resp_rdata, exp_rdata);
    end
    @(negedge axi_clk);
  endtask

  task automatic test_reset_mid();
    bit got;
    set_dly(0, 0, 20, 0, 0);
    @(negedge axi_clk);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h300; req_wdata = 32'h5; req_wstrb = 4'h1;
    @(negedge axi_clk);
    req_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (axi_bready) begin got = 1; break; end
      @(negedge axi_clk);
    end
    total++;
    if (!got) begin bad++; $display("FAIL mid_reach_wresp got=0 exp=1"); end
    #2 axi_resetn = 1'b0;
    #1;
    total++;
    if ({axi_bready, axi_awvalid, axi_wvalid, axi_arvalid, axi_rready, resp_valid} !== 6'b0 ||
        req_ready !== 1'b1) begin
      bad++; $display("FAIL mid_async_reset got=%b ready=%b exp=000000/1",
                      {axi_bready, axi_awvalid, axi_wvalid, axi_arvalid, axi_rready, resp_valid}, req_ready);
    end
    @(negedge axi_clk);
    axi_resetn = 1'b1;
    exp_rdata = 32'h0;
    set_dly(0, 0, 0, 0, 0);
    sl_bresp = 2'b00;
    run_txn(1'b1, 32'h0000_0304, 32'h7777_8888, 4'hC);
  endtask

  task automatic test_random();
    junk_en = 1;
    for (int n = 0; n < 24; n++) begin
      set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3));
      sl_bresp = 2'($urandom); sl_rresp = 2'($urandom); sl_rdata = $urandom;
      run_txn($urandom_range(0, 1) == 1, $urandom, $urandom, 4'($urandom));
    end
    junk_en = 0;
    total++;
    if (stab_err != 0 || inv_err != 0) begin
      bad++; $display("FAIL random_invariants got=%0d/%0d exp=0/0", stab_err, inv_err);
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_write_skew();
    test_read();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
